// File: rtl/axis_miner_bridge.sv
// axis_miner_bridge
//   AXI-Stream front end for the bitcoin miner core. Header beats arriving on
//   the slave stream are assembled (first beat most significant) into one
//   HEADER_BITS word, the miner is kicked with a one-cycle start, and the
//   captured result is returned as a framed master-stream packet, MSW first.
//
// Ports
//   aclk, aresetn         clock, synchronous active-low reset
//   s_axis_*              header input stream (tdata/tvalid/tready/tlast)
//   m_axis_*              result output stream (tdata/tvalid/tready/tlast)
//   header, start         assembled header and start pulse to the miner
//   done, result          miner completion and result (first done cycle used)
//   busy                  frame in flight (first accepted beat .. last result beat)
//   frame_err, err_cnt    framing error pulse and saturating error count
//
// Build option
//   AXIS_MINER_BRIDGE_TLAST_CHECK_EN : when defined, s_axis_tlast must mark
//   exactly beat HDR_BEATS-1; a mismatch discards the frame and counts an
//   error. When undefined, tlast is ignored and frame_err/err_cnt read 0.
module axis_miner_bridge #(
   parameter int DATA_WIDTH  = 32,
   parameter int HEADER_BITS = 640,
   parameter int RESULT_BITS = 32,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
   input  logic                   s_axis_tvalid,
   output logic                   s_axis_tready,
   input  logic                   s_axis_tlast,
   output logic [DATA_WIDTH-1:0]  m_axis_tdata,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic                   m_axis_tlast,
   output logic [HEADER_BITS-1:0] header,
   output logic                   start,
   input  logic                   done,
   input  logic [RESULT_BITS-1:0] result,
   output logic                   busy,
   output logic                   frame_err,
   output logic [CNT_WIDTH-1:0]   err_cnt
);

   localparam int HDR_BEATS = HEADER_BITS / DATA_WIDTH;
   localparam int RES_BEATS = RESULT_BITS / DATA_WIDTH;
   localparam int HBW = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;
   localparam int RBW = (RES_BEATS > 1) ? $clog2(RES_BEATS) : 1;

   typedef enum logic [1:0] {RECV, START, WAIT, SEND} state_t;

   state_t                 r_state, w_next;
   logic [HBW-1:0]         r_hbeat;
   logic [RBW-1:0]         r_rbeat;
   logic [HEADER_BITS-1:0] r_header, w_hdr_next;
   logic [RESULT_BITS-1:0] r_res;

   logic w_s_hs, w_m_hs, w_hdr_last, w_res_last, w_frame_bad;

   assign w_s_hs     = s_axis_tvalid && (r_state == RECV);
   assign w_m_hs     = (r_state == SEND) && m_axis_tready;
   assign w_hdr_last = (r_hbeat == HBW'(HDR_BEATS - 1));
   assign w_res_last = (r_rbeat == RBW'(RES_BEATS - 1));

`ifdef AXIS_MINER_BRIDGE_TLAST_CHECK_EN
   logic                 r_frame_err;
   logic [CNT_WIDTH-1:0] r_err_cnt;

   // tlast must coincide exactly with the final header beat
   assign w_frame_bad = w_s_hs && (s_axis_tlast != w_hdr_last);

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_frame_err <= 1'b0;
         r_err_cnt   <= '0;
      end else begin
         r_frame_err <= w_frame_bad;
         if (w_frame_bad && (r_err_cnt != {CNT_WIDTH{1'b1}}))
            r_err_cnt <= r_err_cnt + 1'b1;
      end
   end

   assign frame_err = r_frame_err;
   assign err_cnt   = r_err_cnt;
`else
   logic w_unused_tlast;
   assign w_unused_tlast = s_axis_tlast;
   assign w_frame_bad    = 1'b0;
   assign frame_err      = 1'b0;
   assign err_cnt        = '0;
`endif

   // state register
   always_ff @(posedge aclk) begin
      if (!aresetn) r_state <= RECV;
      else          r_state <= w_next;
   end

   // next state and state-decoded outputs
   always_comb begin
      w_next        = r_state;
      s_axis_tready = 1'b0;
      start         = 1'b0;
      m_axis_tvalid = 1'b0;
      case (r_state)
         RECV: begin
            s_axis_tready = 1'b1;
            if (w_s_hs && w_hdr_last && !w_frame_bad) w_next = START;
         end
         START: begin
            start  = 1'b1;
            w_next = WAIT;
         end
         WAIT: begin
            if (done) w_next = SEND;
         end
         SEND: begin
            m_axis_tvalid = 1'b1;
            if (w_m_hs && w_res_last) w_next = RECV;
         end
         default: w_next = RECV;
      endcase
   end

   // each accepted beat lands in its own slot; untouched slots keep their value
   always_comb begin
      w_hdr_next = r_header;
      for (int k = 0; k < HDR_BEATS; k++) begin
         if (w_s_hs && (r_hbeat == HBW'(k)))
            w_hdr_next[HEADER_BITS-1-k*DATA_WIDTH -: DATA_WIDTH] = s_axis_tdata;
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_hbeat  <= '0;
         r_rbeat  <= '0;
         r_header <= '0;
         r_res    <= '0;
      end else begin
         r_header <= w_hdr_next;
         if (w_s_hs) begin
            if (w_frame_bad || w_hdr_last) r_hbeat <= '0;
            else                           r_hbeat <= r_hbeat + 1'b1;
         end
         if ((r_state == WAIT) && done) begin
            r_res   <= result;
            r_rbeat <= '0;
         end else if (w_m_hs) begin
            // shifting out leaves zeros behind, so tdata idles at 0 after a packet
            r_res   <= r_res << DATA_WIDTH;
            r_rbeat <= w_res_last ? '0 : r_rbeat + 1'b1;
         end
      end
   end

   assign header       = r_header;
   assign m_axis_tdata = r_res[RESULT_BITS-1 -: DATA_WIDTH];
   assign m_axis_tlast = (r_state == SEND) && w_res_last;
   // a partially received header keeps busy high even though state is RECV
   assign busy         = (r_state != RECV) || (r_hbeat != '0);

endmodule

// File: tb/tb_axis_miner_bridge.sv
module tb_axis_miner_bridge;
   localparam int DW  = 32;
   localparam int HB  = 640;
   localparam int RB  = 64;
   localparam int CW  = 16;
   localparam int HDR = HB / DW;
   localparam int RES = RB / DW;

   logic          aclk, aresetn;
   logic [DW-1:0] s_axis_tdata;
   logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
   logic [HB-1:0] header;
   logic          start, done, busy, frame_err;
   logic [RB-1:0] result;
   logic [CW-1:0] err_cnt;

   axis_miner_bridge #(.DATA_WIDTH(DW), .HEADER_BITS(HB), .RESULT_BITS(RB), .CNT_WIDTH(CW)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
      .header(header), .start(start), .done(done), .result(result),
      .busy(busy), .frame_err(frame_err), .err_cnt(err_cnt)
   );

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   int errs = 0;
   int checks = 0;

   // reference model: header slots, beats pending in the current frame, error count
   logic [DW-1:0] slot [HDR];
   logic [DW-1:0] wbuf [HDR];
   int            pend;
   int            m_err;

   task automatic chk(input string tag, input logic [HB-1:0] got, input logic [HB-1:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   function automatic logic [HB-1:0] model_hdr();
      logic [HB-1:0] h = '0;
      for (int k = 0; k < HDR; k++) h = (h << DW) | HB'(slot[k]);
      return h;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < HDR; k++) slot[k] = '0;
      pend  = 0;
      m_err = 0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_sready"}, s_axis_tready, 1);
      chk({tag, "_mvalid"}, m_axis_tvalid, 0);
      chk({tag, "_mlast"},  m_axis_tlast, 0);
      chk({tag, "_mdata"},  m_axis_tdata, 0);
      chk({tag, "_start"},  start, 0);
      chk({tag, "_busy"},   busy, 0);
      chk({tag, "_ferr"},   frame_err, 0);
      chk({tag, "_errcnt"}, err_cnt, 0);
      chk({tag, "_header"}, header, 0);
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b0;
      done = 1'b0;
      step();
      check_reset_vals("rst");
      aresetn = 1'b1;
      model_clear();
   endtask

   // one header beat with random leading idle cycles; done is random noise since RECV ignores it
   task automatic drive_beat(input logic [DW-1:0] w, input logic tl, output logic started);
      logic exp_start, exp_ferr;
      repeat ($urandom_range(0, 2)) begin
         s_axis_tvalid = 1'b0;
         s_axis_tdata  = $urandom;
         s_axis_tlast  = 1'($urandom);
         done          = 1'($urandom);
         result        = {$urandom, $urandom};
         step();
         chk("idle_start", start, 0);
         chk("idle_hdr", header, model_hdr());
      end
      s_axis_tdata  = w;
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = tl;
      done          = 1'($urandom);
      chk("beat_sready", s_axis_tready, 1);
      step();
      s_axis_tvalid = 1'b0;
      done          = 1'b0;
      slot[pend] = w;
      pend++;
      exp_start = 1'b0;
      exp_ferr  = 1'b0;
`ifdef AXIS_MINER_BRIDGE_TLAST_CHECK_EN
      if ((tl && pend < HDR) || (!tl && pend == HDR)) begin
         exp_ferr = 1'b1;
         pend = 0;
         if (m_err < (1 << CW) - 1) m_err++;
      end else if (pend == HDR) begin
         exp_start = 1'b1;
         pend = 0;
      end
`else
      if (pend == HDR) begin
         exp_start = 1'b1;
         pend = 0;
      end
`endif
      chk("beat_start",  start, exp_start);
      chk("beat_ferr",   frame_err, exp_ferr);
      chk("beat_errcnt", err_cnt, m_err);
      chk("beat_sready_after", s_axis_tready, !exp_start);
      chk("beat_header", header, model_hdr());
      chk("beat_busy",   busy, (pend != 0) || exp_start);
      started = exp_start;
   endtask

   // sends wbuf[0..n-1]; tlast on index tl_at (-1 for none)
   task automatic frame(input int n, input int tl_at, output logic started);
      started = 1'b0;
      for (int k = 0; k < n; k++) drive_beat(wbuf[k], (k == tl_at), started);
   endtask

   task automatic fill_random();
      for (int k = 0; k < HDR; k++) wbuf[k] = $urandom;
   endtask

   // entered in the START cycle; mode 0 = 2-low/6-high ready, 1 = random ready
   task automatic mine(input logic [RB-1:0] r, input int mode);
      logic [DW-1:0] ew [RES];
      logic [RB-1:0] t;
      logic          rdy;
      int            i, cyc;
      t = r;
      for (int k = 0; k < RES; k++) begin
         ew[k] = t[RB-1 -: DW];
         t = t << DW;
      end
      done = 1'b1;               // seen in START: must be ignored
      result = ~r;
      step();
      chk("wait_start", start, 0);
      chk("wait_busy", busy, 1);
      done = 1'b0;
      repeat ($urandom_range(0, 3)) begin
         step();
         chk("wait_mvalid", m_axis_tvalid, 0);
      end
      chk("wait_mvalid_pre", m_axis_tvalid, 0);
      done = 1'b1;
      result = r;
      step();
      result = {$urandom, $urandom};   // only the first done cycle counts
      done = 1'($urandom);
      i = 0;
      cyc = 0;
      while (i < RES && cyc < 200) begin
         chk("send_mvalid", m_axis_tvalid, 1);
         chk("send_mdata",  m_axis_tdata, ew[i]);
         chk("send_mlast",  m_axis_tlast, (i == RES - 1));
         chk("send_sready", s_axis_tready, 0);
         chk("send_busy",   busy, 1);
         rdy = (mode == 0) ? ((cyc % 8) >= 2) : 1'($urandom);
         m_axis_tready = rdy;
         step();
         if (rdy) i++;
         cyc++;
      end
      chk("send_count", i, RES);
      m_axis_tready = 1'b0;
      done = 1'b0;
      chk("end_sready", s_axis_tready, 1);
      chk("end_busy",   busy, 0);
      chk("end_mvalid", m_axis_tvalid, 0);
   endtask

   initial begin
      logic st;
      aresetn = 1'b0;
      s_axis_tdata = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast = 1'b0;
      m_axis_tready = 1'b0;
      done = 1'b0;
      result = '0;
      model_clear();
      step();
      do_reset();
      step();
      check_reset_vals("idle");

      // nominal header with fixed first/last words, backpressured result
      fill_random();
      wbuf[0]   = 32'h02000000;
      wbuf[HDR-1] = 32'h43F740C0;
      frame(HDR, HDR - 1, st);
      chk("nom_started", st, 1);
      chk("nom_hdr_top", header[HB-1 -: DW], 32'h02000000);
      chk("nom_hdr_bot", header[DW-1:0], 32'h43F740C0);
      mine(64'h11223344_55667788, 0);

      // early TLAST on the 7th beat
      fill_random();
`ifdef AXIS_MINER_BRIDGE_TLAST_CHECK_EN
      frame(7, 6, st);
      chk("early_nostart", st, 0);
      step();
      chk("early_ferr_once", frame_err, 0);
      chk("early_errcnt", err_cnt, 1);
`else
      frame(7, 6, st);
      chk("early_nostart", st, 0);
      for (int k = 7; k < HDR; k++) wbuf[k - 7] = wbuf[k];
      frame(HDR - 7, HDR - 8, st);
      chk("early_ignored_started", st, 1);
      mine({$urandom, $urandom}, 1);
`endif
      fill_random();
      frame(HDR, HDR - 1, st);
      chk("clean_started", st, 1);
      mine({$urandom, $urandom}, 1);

      // missing TLAST on the final beat
      fill_random();
      frame(HDR, -1, st);
      if (st) mine({$urandom, $urandom}, 0);

      // reset after 10 beats, then a full frame must carry no residue
      fill_random();
      frame(10, -1, st);
      chk("midrst_busy", busy, 1);
      do_reset();
      fill_random();
      frame(HDR, HDR - 1, st);
      chk("postrst_started", st, 1);
      mine({$urandom, $urandom}, 1);

      // random frames
      for (int n = 0; n < 4; n++) begin
         fill_random();
         frame(HDR, HDR - 1, st);
         chk("rand_started", st, 1);
         mine({$urandom, $urandom}, n % 2);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/axis_miner_bridge.md
# axis_miner_bridge

Parametrised AXI-Stream front end for the bitcoin miner core. It accepts a block header as a stream of `DATA_WIDTH`-bit beats and assembles it into one `HEADER_BITS`-wide word. It pulses the miner's start, waits for the miner's done, then returns the miner result as a framed AXI-Stream packet. It replaces the fixed 32-bit, unframed path in the miner IP, adding configurable width, result length, backpressure on both sides and frame checking.

## Interface
Parameters:
- `DATA_WIDTH`, 32: TDATA width in bits. Multiple of 8.
- `HEADER_BITS`, 640: assembled header width. Must be a multiple of `DATA_WIDTH`; `HDR_BEATS = HEADER_BITS/DATA_WIDTH`.
- `RESULT_BITS`, 32: miner result width. Must be a multiple of `DATA_WIDTH`; `RES_BEATS = RESULT_BITS/DATA_WIDTH`.
- `CNT_WIDTH`, 16: width of the error counter.

Ports:
- `aclk` in 1: single clock. All logic on the rising edge.
- `aresetn` in 1: synchronous, active-low reset.
- `s_axis_tdata` in `DATA_WIDTH`: header beat.
- `s_axis_tvalid` in 1: beat valid.
- `s_axis_tready` out 1: bridge accepts a beat.
- `s_axis_tlast` in 1: final beat of the frame.
- `m_axis_tdata` out `DATA_WIDTH`: result beat.
- `m_axis_tvalid` out 1: result beat valid.
- `m_axis_tready` in 1: downstream accepts the beat.
- `m_axis_tlast` out 1: final result beat.
- `header` out `HEADER_BITS`: assembled header to the miner.
- `start` out 1: one-cycle start pulse to the miner.
- `done` in 1: miner completion. Level or pulse; only the first high cycle matters.
- `result` in `RESULT_BITS`: miner result, valid while `done` is high.
- `busy` out 1: high from the first accepted beat until the last result beat completes.
- `frame_err` out 1: one-cycle pulse on a framing error (only with the macro).
- `err_cnt` out `CNT_WIDTH`: saturating count of framing errors.

## Operation
- The FSM has four states: `RECV`, `START`, `WAIT`, `SEND`. Reset state is `RECV`.
- **`RECV`:**
  - `s_axis_tready`=1.
  - Each handshake (`tvalid && tready`) writes beat k (0-based) into `header[HEADER_BITS-1-k*DATA_WIDTH -: DATA_WIDTH]`. The first beat is most significant; TDATA is not byte-swapped.
  - The beat counter increments on each handshake. On beat `HDR_BEATS-1` the FSM goes to `START`.
- **`START`:** `start`=1 for exactly this cycle; `header` is stable. Next state is `WAIT`.
- **`WAIT`:**
  - `done` is sampled from the cycle after `start`.
  - On the first `done`=1, `result` is captured into the shift register. Next state is `SEND`.
- **`SEND`:**
  - Beats are emitted most-significant word first.
  - `m_axis_tlast`=1 on beat `RES_BEATS-1`.
  - The beat advances only on `m_axis_tvalid && m_axis_tready`.
  - After the last handshake the FSM returns to `RECV` and the counters clear.
- `header` holds its value until the next frame's first accepted beat overwrites it.
- `s_axis_tready`=0 in every state other than `RECV`. A new header is never accepted while mining.
- `err_cnt` saturates at all-ones.

## Timing
- Reset values: `s_axis_tready`=1 (first cycle after reset release). `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `start`=0, `busy`=0, `frame_err`=0, `err_cnt`=0, `header`=0.
- Last header beat handshake in cycle N: `start`=1 in N+1, `s_axis_tready`=0 from N+1.
- `done` first seen in cycle M: `m_axis_tvalid`=1 from M+1.
- `m_axis_tvalid` never deasserts before its handshake. TDATA and TLAST are stable while TVALID=1 and TREADY=0.
- Last result handshake in cycle P: `s_axis_tready`=1 in P+1, `busy`=0 in P+1.
- `done` asserted during `RECV` or `START` is ignored.
- `aresetn`=0 in any state, including mid-frame or mid-SEND: the next edge returns all outputs to reset values and drops any partial frame. `err_cnt` is cleared.

## Configuration
- Macro: `AXIS_MINER_BRIDGE_TLAST_CHECK_EN`.
- **Defined:**
  - `s_axis_tlast`=1 on beat k < `HDR_BEATS-1`: the frame is discarded, `frame_err` pulses the next cycle, `err_cnt`+1, counter resets, and the FSM stays in `RECV`.
  - `s_axis_tlast`=0 on beat `HDR_BEATS-1`: same error handling, and no `start` is issued.
- **Undefined:**
  - `s_axis_tlast` is ignored; every `HDR_BEATS` accepted beats form a header.
  - `frame_err` is tied 0 and `err_cnt` is tied 0.

## Test plan
- **Nominal 32-bit header:** defaults, 20 beats, first 0x02000000, last 0x43F740C0 with TLAST.
  - `header[639:608]`=0x02000000, `header[31:0]`=0x43F740C0.
  - `start` high exactly one cycle, the cycle after beat 20.
- **Result return:** `done`=1 with `result`=0x43F740C0.
  - One master beat 0x43F740C0 with TLAST=1.
  - `busy` falls the cycle after the handshake.
- **Backpressure:** master side oscillates `m_axis_tready` low 2 cycles, high 6 cycles; `RESULT_BITS`=64, `result`=0x11223344_55667788.
  - Beats are 0x11223344 then 0x55667788(TLAST), each held stable while TREADY=0.
  - Slave side stays stalled until the last handshake.
- **Early TLAST (macro on):** TLAST on beat 7.
  - `frame_err` pulses, `err_cnt`=1, no `start`.
  - A following clean 20-beat frame is accepted and mined normally.
- **Reset mid-frame:** `aresetn`=0 for 1 cycle after beat 10.
  - All outputs return to reset values.
  - A subsequent 20-beat frame assembles correctly with no residue from the first.
- **Width variant:** `DATA_WIDTH`=64, `HEADER_BITS`=640.
  - 10 beats trigger `start`.
  - Beat 0 = 0x02000000_671D0E2F lands in `header[639:576]`.
